// File: rtl/rgb_to_yuv_convert_if.sv
// Pixel request/result bundle for the RGB-to-YUV converter.
// The master drives the pixel and start; the slave returns busy, done and Y/U/V.
interface rgb_to_yuv_convert_if;
    logic [7:0] R;
    logic [7:0] G;
    logic [7:0] B;
    logic       start;
    logic       busy;
    logic       done;
    logic [7:0] Y;
    logic [7:0] U;
    logic [7:0] V;

    modport master (
        output R, G, B, start,
        input  busy, done, Y, U, V
    );

    modport slave (
        input  R, G, B, start,
        output busy, done, Y, U, V
    );
endinterface

// File: rtl/rgb_to_yuv_convert.sv
// BT.601 studio-range RGB->YUV using one shared 9x18 multiplier and three accumulators.
// Latency 10 cycles from accepted start to done; start is ignored while busy (no queuing).
module rgb_to_yuv_convert (
    input  logic                 Clock,
    input  logic                 Resetn,
    rgb_to_yuv_convert_if.slave  pix
);

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_MAC   = 2'd1,
        S_FINAL = 2'd2
    } state_t;

    localparam logic signed [31:0] OFS_Y  = 32'sd1081344;  // (16 << 16) + half LSB
    localparam logic signed [31:0] OFS_UV = 32'sd8421376;  // (128 << 16) + half LSB

    state_t             state;
    logic [3:0]         cnt;
    logic [7:0]         r_q;
    logic [7:0]         g_q;
    logic [7:0]         b_q;
    logic signed [31:0] acc_y;
    logic signed [31:0] acc_u;
    logic signed [31:0] acc_v;

    logic [7:0]         opnd;
    logic signed [17:0] coef;
    logic [1:0]         acc_sel;
    logic signed [26:0] prod;
    logic signed [31:0] prod_ext;

    // Product schedule: three products per accumulator, R/G/B order within each.
    always_comb begin
        opnd    = r_q;
        coef    = 18'sd0;
        acc_sel = 2'd0;
        case (cnt)
            4'd0: begin opnd = r_q; coef =  18'sd16843; acc_sel = 2'd0; end
            4'd1: begin opnd = g_q; coef =  18'sd33030; acc_sel = 2'd0; end
            4'd2: begin opnd = b_q; coef =  18'sd6423;  acc_sel = 2'd0; end
            4'd3: begin opnd = r_q; coef = -18'sd9699;  acc_sel = 2'd1; end
            4'd4: begin opnd = g_q; coef = -18'sd19071; acc_sel = 2'd1; end
            4'd5: begin opnd = b_q; coef =  18'sd28770; acc_sel = 2'd1; end
            4'd6: begin opnd = r_q; coef =  18'sd28770; acc_sel = 2'd2; end
            4'd7: begin opnd = g_q; coef = -18'sd24117; acc_sel = 2'd2; end
            4'd8: begin opnd = b_q; coef = -18'sd4653;  acc_sel = 2'd2; end
            default: begin opnd = r_q; coef = 18'sd0; acc_sel = 2'd3; end
        endcase
    end

    assign prod     = $signed({1'b0, opnd}) * coef;
    assign prod_ext = {{5{prod[26]}}, prod};

    function automatic logic [7:0] round_clip(input logic signed [31:0] acc,
                                              input logic signed [31:0] ofs);
        logic signed [31:0] s;
        s = (acc + ofs) >>> 16;
        if (s[31])
            return 8'd0;
        else if (|s[30:8])
            return 8'd255;
        else
            return s[7:0];
    endfunction

    always_ff @(posedge Clock or negedge Resetn) begin
        if (!Resetn) begin
            state    <= S_IDLE;
            cnt      <= 4'd0;
            r_q      <= 8'd0;
            g_q      <= 8'd0;
            b_q      <= 8'd0;
            acc_y    <= 32'sd0;
            acc_u    <= 32'sd0;
            acc_v    <= 32'sd0;
            pix.busy <= 1'b0;
            pix.done <= 1'b0;
            pix.Y    <= 8'd0;
            pix.U    <= 8'd0;
            pix.V    <= 8'd0;
        end else begin
            pix.done <= 1'b0;
            case (state)
                S_IDLE: begin
                    if (pix.start) begin
                        r_q      <= pix.R;
                        g_q      <= pix.G;
                        b_q      <= pix.B;
                        cnt      <= 4'd0;
                        acc_y    <= 32'sd0;
                        acc_u    <= 32'sd0;
                        acc_v    <= 32'sd0;
                        pix.busy <= 1'b1;
                        state    <= S_MAC;
                    end
                end
                S_MAC: begin
                    case (acc_sel)
                        2'd0:    acc_y <= acc_y + prod_ext;
                        2'd1:    acc_u <= acc_u + prod_ext;
                        2'd2:    acc_v <= acc_v + prod_ext;
                        default: ;
                    endcase
                    if (cnt == 4'd8)
                        state <= S_FINAL;
                    else
                        cnt <= cnt + 4'd1;
                end
                S_FINAL: begin
                    pix.Y    <= round_clip(acc_y, OFS_Y);
                    pix.U    <= round_clip(acc_u, OFS_UV);
                    pix.V    <= round_clip(acc_v, OFS_UV);
                    pix.done <= 1'b1;
                    pix.busy <= 1'b0;
                    state    <= S_IDLE;
                end
                default: begin
                    pix.busy <= 1'b0;
                    state    <= S_IDLE;
                end
            endcase
        end
    end

endmodule
